// File: rtl/rom_pkg.sv
// rom_pkg: shared ROM geometry, reader FSM states and reference ROM contents
package rom_pkg;
    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, ADDR, OUT, DONE} state_t;
    localparam logic [ROM_DATA_W-1:0] ROM_TABLE [0:7] = '{
        8'd21, 8'd255, 8'd33, 8'd99, 8'd127, 8'd13, 8'd10, 8'd88
    };
    function automatic logic [ROM_DATA_W-1:0] rom_word(input logic [ROM_ADDR_W-1:0] a);
        return ROM_TABLE[a];
    endfunction
endpackage

// File: rtl/rom_seq_reader.sv
// rom_seq_reader: bursts consecutive ROM reads out on a valid/ready stream with a checksum
module rom_seq_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              rom_cs,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    state_t state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0] remain;
    logic [DATA_W-1:0] acc;
    logic [CW-1:0] cnt;
    logic settled, hs;

    // state register; reset aborts any burst immediately
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nxt;
    end

    // next state and ROM-side outputs; ROM is driven only in ADDR
    always_comb begin
        state_nxt = state;
        busy      = state != IDLE;
        done      = state == DONE;
        rom_cs    = state == ADDR;
        rom_rd_en = state == ADDR;
        rom_addr  = cur_addr;
        settled   = state == ADDR && cnt == CW'(SETTLE - 1);
        hs        = state == OUT && out_valid && out_ready;
        case (state)
            IDLE: if (start) state_nxt = len == '0 ? DONE : ADDR;
            ADDR: if (settled) state_nxt = OUT;
            OUT:  if (hs) state_nxt = remain > 1 ? ADDR : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: latch command, sample ROM after settling, hand bytes off, publish checksum on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remain    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sum       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cur_addr <= base;
                remain   <= len;
                acc      <= '0;
                cnt      <= '0;
                if (len == '0) sum <= '0;
            end
            if (state == ADDR) begin
                cnt <= settled ? '0 : cnt + 1'b1;
                if (settled) begin
                    out_data  <= rom_data;
                    acc       <= acc + rom_data;
                    out_valid <= 1'b1;
                end
            end
            if (hs) begin
                out_valid <= 1'b0;
                remain    <= remain - 1'b1;
                if (remain > 1) cur_addr <= cur_addr + 1'b1;
                else sum <= acc;
            end
        end
    end
endmodule

// File: tb/tb_rom_seq_reader.sv
// tb_rom_seq_reader: scoreboard bench for rom_seq_reader against a combinational ROM model
module tb_rom_seq_reader;
    import rom_pkg::*;

    logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
    logic [2:0] base = '0;
    logic [3:0] len = '0;
    logic busy, done, rom_cs, rom_rd_en, out_valid;
    logic [2:0] rom_addr;
    logic [7:0] sum, out_data;
    wire  [7:0] rom_data;
    int errors = 0, checks = 0;
    logic [7:0] q[$];

    rom_seq_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .sum(sum), .rom_cs(rom_cs), .rom_rd_en(rom_rd_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    assign rom_data = (rom_cs && rom_rd_en) ? rom_word(rom_addr) : 8'hzz;

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rom_cs, rom_rd_en, out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, rom_cs, rom_rd_en, out_valid});
        end
        checks++;
        if ({rom_addr, out_data, sum} !== 19'd0) begin
            errors++;
            $display("FAIL reset_data got addr=%0d data=%0d sum=%0d exp=0", rom_addr, out_data, sum);
        end
        rst_n = 1;
    endtask

    task automatic test_burst(input logic [2:0] b, input logic [3:0] n, input logic [7:0] exp_sum,
                              input int stall, input int poke);
        int last_hs, stall_left, cyc;
        bit fin;
        logic [2:0] a;
        logic [7:0] exp;
        q.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = b + 3'(i);
            q.push_back(rom_word(a));
        end
        @(negedge clk);
        start = 1; base = b; len = n; out_ready = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got=%b exp=1", busy); end
        last_hs = -1; stall_left = stall; fin = 0;
        for (cyc = 0; cyc < 200 && !fin; cyc++) begin
            start = (cyc == poke);
            if (cyc == poke) begin base = ~b; len = 4'd1; end
            if (done) begin
                checks++;
                if (sum !== exp_sum) begin errors++; $display("FAIL sum base=%0d got=%0d exp=%0d", b, sum, exp_sum); end
                checks++;
                if (q.size() != 0) begin errors++; $display("FAIL beats_missing base=%0d got_left=%0d exp=0", b, q.size()); end
                fin = 1;
            end else if ((out_valid || stall_left < stall) && stall_left > 0) begin
                out_ready = 0;
                exp = q.size() > 0 ? q[0] : 8'hxx;
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b data=%0d exp valid=1 data=%0d", out_valid, out_data, exp);
                end
                stall_left--;
            end else begin
                out_ready = 1;
                if (out_valid) begin
                    checks++;
                    if (rom_cs !== 1'b0) begin errors++; $display("FAIL rom_cs_in_out got=%b exp=0", rom_cs); end
                    exp = q.size() > 0 ? q.pop_front() : 8'hxx;
                    checks++;
                    if (out_data !== exp) begin errors++; $display("FAIL beat_data got=%0d exp=%0d", out_data, exp); end
                    if (stall == 0 && last_hs >= 0) begin
                        checks++;
                        if (cyc - last_hs != 2) begin errors++; $display("FAIL beat_period got=%0d exp=2", cyc - last_hs); end
                    end
                    last_hs = cyc;
                end
            end
            if (!fin) @(negedge clk);
        end
        start = 0; out_ready = 1;
        if (!fin) begin errors++; checks++; $display("FAIL done_timeout base=%0d got=none exp=done", b); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done got done=%b busy=%b exp=0 0", done, busy);
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start = 1; base = 3'd5; len = 4'd0;
        @(negedge clk);
        start = 0;
        checks++;
        if ({done, busy, rom_cs} !== 3'b110 || sum !== 8'd0) begin
            errors++;
            $display("FAIL zero_len got done=%b busy=%b cs=%b sum=%0d exp=1 1 0 0", done, busy, rom_cs, sum);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, rom_cs} !== 3'b000) begin
            errors++;
            $display("FAIL zero_len_end got=%b exp=000", {done, busy, rom_cs});
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        @(negedge clk);
        start = 1; base = 3'd0; len = 4'd8; out_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (rom_cs !== 1'b1 || rom_addr !== 3'd1) begin
            errors++;
            $display("FAIL beat2_addr got cs=%b addr=%0d exp=1 1", rom_cs, rom_addr);
        end
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({busy, done, rom_cs, rom_rd_en, out_valid, rom_addr, out_data, sum} !== 24'd0) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=0", {busy, done, rom_cs, rom_rd_en, out_valid, rom_addr, out_data, sum});
        end
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL mid_reset_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_burst(3'd2, 4'd3, 8'd3, 0, -1);
        test_burst(3'd6, 4'd4, 8'd118, 0, -1);
        test_burst(3'd0, 4'd8, 8'd134, 0, -1);
        test_burst(3'd4, 4'd2, 8'd140, 5, -1);
        test_zero_len();
        test_burst(3'd2, 4'd3, 8'd3, 0, 1);
        test_reset_mid();
        test_burst(3'd1, 4'd1, 8'd255, 0, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
